// File: rtl/crypt_pkg.sv
`default_nettype none
// ============================================================================
// crypt_pkg : keys, key index type and the byte permutation shared by the
//             encryption and decryption blocks.
// Revision  : 1.0
// ============================================================================
package crypt_pkg;

  localparam int CNT_MAX = 3;

  localparam logic [7:0] K1 = 8'h3E;
  localparam logic [7:0] K2 = 8'h49;
  localparam logic [7:0] K3 = 8'h7E;

  typedef logic [1:0] key_idx_t;

  // Forward permutation applied by the encryption side before the key XOR.
  function automatic logic [7:0] perm8(input logic [7:0] y);
    return {y[0], y[5], y[2], y[6], y[7], y[4], y[3], y[1]};
  endfunction

  function automatic logic [7:0] unperm8(input logic [7:0] x);
    return {x[3], x[4], x[6], x[2], x[1], x[5], x[0], x[7]};
  endfunction

  function automatic logic [7:0] key_of(input key_idx_t idx);
    logic [7:0] k;
    case (idx)
      2'd0:    k = K1;
      2'd1:    k = K2;
      2'd2:    k = K3;
      default: k = K1;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypt_key_seq.sv
`default_nettype none
// ============================================================================
// crypt_key_seq : rotating key index with advance, resync and wrap.
// Revision      : 1.0
// ============================================================================
module crypt_key_seq
  import crypt_pkg::*;
#(
  parameter int CNT_MAX = crypt_pkg::CNT_MAX
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       advance_i,
  input  logic       sync_i,
  output logic [7:0] key_o
);

  localparam key_idx_t LAST_IDX = key_idx_t'(CNT_MAX - 1);

  key_idx_t idx_q;
  key_idx_t idx_d;
  key_idx_t cur_idx;

  // A sync arriving with the byte forces that byte onto the first key.
  always_comb begin
    cur_idx = sync_i ? key_idx_t'(0) : idx_q;
    idx_d   = idx_q;
    if (advance_i) begin
      idx_d = (cur_idx == LAST_IDX) ? key_idx_t'(0) : cur_idx + key_idx_t'(1);
    end else if (sync_i) begin
      idx_d = key_idx_t'(0);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      idx_q <= key_idx_t'(0);
    end else begin
      idx_q <= idx_d;
    end
  end

  assign key_o = key_of(cur_idx);

endmodule
`default_nettype wire

// File: rtl/decryption.sv
`default_nettype none
// ============================================================================
// decryption : two-stage valid/ready pipeline, key XOR then inverse permute.
// Revision   : 1.0
// ============================================================================
module decryption
  import crypt_pkg::*;
#(
  parameter int N       = 8,
  parameter int CNT_MAX = crypt_pkg::CNT_MAX
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] din,
  output logic         rdy,
  input  logic         sync,
  output logic [N-1:0] dout,
  output logic         v,
  input  logic         out_rdy
);

  logic [N-1:0] s1_data_q, s1_data_d;
  logic [N-1:0] s2_data_q, s2_data_d;
  logic         s1_val_q,  s1_val_d;
  logic         s2_val_q,  s2_val_d;
  logic         s2_load;
  logic         accept;
  logic [7:0]   key;

  // Ready looks only at out_rdy and internal state, never at en.
  assign s2_load = !s2_val_q || out_rdy;
  assign rdy     = !s1_val_q || s2_load;
  assign accept  = en && rdy;

  crypt_key_seq #(
    .CNT_MAX (CNT_MAX)
  ) u_key_seq (
    .clock     (clock),
    .rst       (rst),
    .advance_i (accept),
    .sync_i    (sync),
    .key_o     (key)
  );

  always_comb begin
    s1_data_d = s1_data_q;
    s1_val_d  = s1_val_q;
    s2_data_d = s2_data_q;
    s2_val_d  = s2_val_q;
    if (s2_load) begin
      s2_val_d = s1_val_q;
      if (s1_val_q) begin
        s2_data_d = unperm8(s1_data_q);
      end
      s1_val_d = 1'b0;
    end
    if (accept) begin
      s1_val_d  = 1'b1;
      s1_data_d = din ^ key;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      s1_data_q <= '0;
      s1_val_q  <= 1'b0;
      s2_data_q <= '0;
      s2_val_q  <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_val_q  <= s1_val_d;
      s2_data_q <= s2_data_d;
      s2_val_q  <= s2_val_d;
    end
  end

  assign dout = s2_data_q;
  assign v    = s2_val_q;

endmodule
`default_nettype wire
